checkpoint_seq_monitor: RTL

Synthesizable monitor that watches a GPIO-mapped checkpoint bus (firmware-driven status word on mprj_io) for an ordered sequence of up to MAX_CHECKS expected codes, with glitch filtering, optional strict ordering and a cycle timeout. It replaces hand-written wait() chains in DV benches and can also be instantiated in the user project for on-chip self-test status reporting. Results are reported as pass/fail flags, a fail reason, the offending code and a progress index.

---
 rtl/checkpoint_seq_monitor.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint sequence monitor: watches a firmware-driven status bus for an ordered
// list of expected codes, with glitch filtering, optional strict ordering and timeout.
module checkpoint_seq_monitor #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned MAX_CHECKS    = 8,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 24
) (
  input  logic                            clock,
  input  logic                            resetb,
  input  logic                            start,
  input  logic                            strict,
  input  logic [$clog2(MAX_CHECKS+1)-1:0] num_checks,
  input  logic [MAX_CHECKS*WIDTH-1:0]     expected,
  input  logic [CNT_W-1:0]                timeout_limit,
  input  logic [WIDTH-1:0]                checkbits,
  output logic                            busy,
  output logic                            pass,
  output logic                            fail,
  output logic [1:0]                      fail_reason,
  output logic [WIDTH-1:0]                fail_code,
  output logic [$clog2(MAX_CHECKS+1)-1:0] progress,
  output logic                            match_pulse
);

  localparam int unsigned PW   = $clog2(MAX_CHECKS + 1);
  localparam int unsigned IdxW = (MAX_CHECKS > 1) ? $clog2(MAX_CHECKS) : 1;
  localparam int unsigned RunW = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] ReasonNone    = 2'b00;
  localparam logic [1:0] ReasonStrict  = 2'b01;
  localparam logic [1:0] ReasonTimeout = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  state_e                             state_q, state_d;
  logic                               strict_q;
  logic [PW-1:0]                      num_q, num_eff;
  logic [MAX_CHECKS-1:0][WIDTH-1:0]   exp_q;
  logic [CNT_W-1:0]                   limit_q;
  logic [CNT_W-1:0]                   tcnt_q, tcnt_d;
  logic [PW-1:0]                      progress_q, progress_d;
  logic                               match_q, match_d;
  logic [1:0]                         reason_q, reason_d;
  logic [WIDTH-1:0]                   code_q, code_d;
  logic [IdxW-1:0]                    cur_idx, prev_idx;
  logic [WIDTH-1:0]                   cur_exp, prev_exp;

  // Stability filter state
  logic [WIDTH-1:0] last_q, stable_q;
  logic [RunW-1:0]  run_q, run_d;
  logic             stable_vld_q;
  logic             same_val;
  logic             stable_ev;

  // Filter: count consecutive identical samples; fire once when a run reaches
  // STABLE_CYCLES, unless it merely returns to the last stable value.
  always_comb begin
    same_val = (run_q != '0) && (checkbits == last_q);
    if (same_val) begin
      run_d = (run_q == RunW'(STABLE_CYCLES)) ? run_q : run_q + 1'b1;
    end else begin
      run_d = RunW'(1);
    end
    stable_ev = (run_d == RunW'(STABLE_CYCLES)) &&
                !(same_val && (run_q == RunW'(STABLE_CYCLES))) &&
                (!stable_vld_q || (checkbits != stable_q));
  end

  // Filter registers; start restarts filtering so a value held across start counts again.
  always_ff @(posedge clock) begin
    if (!resetb || start) begin
      last_q       <= '0;
      run_q        <= '0;
      stable_q     <= '0;
      stable_vld_q <= 1'b0;
    end else begin
      last_q <= checkbits;
      run_q  <= run_d;
      if (stable_ev) begin
        stable_q     <= checkbits;
        stable_vld_q <= 1'b1;
      end
    end
  end

  // Configuration capture at start; num_checks clamped to the table size.
  always_comb begin
    num_eff = (num_checks > PW'(MAX_CHECKS)) ? PW'(MAX_CHECKS) : num_checks;
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      strict_q <= 1'b0;
      num_q    <= '0;
      exp_q    <= '0;
      limit_q  <= '0;
    end else if (start) begin
      strict_q <= strict;
      num_q    <= num_eff;
      exp_q    <= expected;
      limit_q  <= timeout_limit;
    end
  end

  // Next-state: match/strict/timeout decisions; final match beats timeout, strict fail
  // beats timeout. The timeout fires on the edge where the count reaches the limit.
  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    match_d    = 1'b0;
    reason_d   = reason_q;
    code_d     = code_q;
    tcnt_d     = tcnt_q;
    cur_idx    = IdxW'(progress_q);
    prev_idx   = IdxW'(progress_q - 1'b1);
    cur_exp    = exp_q[cur_idx];
    prev_exp   = exp_q[prev_idx];

    if (start) begin
      state_d    = (num_eff == '0) ? StPass : StRun;
      progress_d = '0;
      reason_d   = ReasonNone;
      code_d     = '0;
      tcnt_d     = '0;
    end else if (state_q == StRun) begin
      tcnt_d = tcnt_q + 1'b1;
      if (stable_ev && (checkbits == cur_exp)) begin
        progress_d = progress_q + 1'b1;
        match_d    = 1'b1;
        if (progress_d == num_q) begin
          state_d = StPass;
        end
      end else if (stable_ev && strict_q && (progress_q != '0) && (checkbits != prev_exp)) begin
        state_d  = StFail;
        reason_d = ReasonStrict;
        code_d   = checkbits;
      end
      if ((state_d == StRun) && (limit_q != '0) && (tcnt_d == limit_q)) begin
        state_d  = StFail;
        reason_d = ReasonTimeout;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q    <= StIdle;
      progress_q <= '0;
      match_q    <= 1'b0;
      reason_q   <= ReasonNone;
      code_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      match_q    <= match_d;
      reason_q   <= reason_d;
      code_q     <= code_d;
      tcnt_q     <= tcnt_d;
    end
  end

  // Outputs decoded from state and result registers.
  always_comb begin
    busy        = (state_q == StRun);
    pass        = (state_q == StPass);
    fail        = (state_q == StFail);
    fail_reason = reason_q;
    fail_code   = code_q;
    progress    = progress_q;
    match_pulse = match_q;
  end

endmodule
